// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, beq resolution and a single-entry output
// register with valid/ready handshake, stall hold and flush.
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [3:0]      id_alu_ctrl,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_alu_src,
  input  logic            id_branch,
  input  logic            id_reg_write,
  input  logic [4:0]      id_rd,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  input  logic            mem_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_alu_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_branch_target,
  output logic            ex_zero,
  output logic            ex_branch_taken,
  output logic            ex_reg_write,
  output logic            ex_illegal,
  output logic [4:0]      ex_rd
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b1000;
  localparam logic [3:0] OpAnd = 4'b0111;
  localparam logic [3:0] OpOr  = 4'b0110;
  localparam logic [3:0] OpXor = 4'b0101;

  logic [XLEN-1:0] op_a, fwd_b, op_b, alu_res;
  logic            alu_illegal, alu_zero, accept;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] store_q, store_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            zero_q, zero_d;
  logic            taken_q, taken_d;
  logic            reg_write_q, reg_write_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      rd_q, rd_d;

  always_comb begin
    op_a = id_rs1_data;
    case (fwd_a_sel)
      2'b01:   op_a = fwd_wb_data;
      2'b10:   op_a = fwd_mem_data;
      default: op_a = id_rs1_data;
    endcase
  end

  always_comb begin
    fwd_b = id_rs2_data;
    case (fwd_b_sel)
      2'b01:   fwd_b = fwd_wb_data;
      2'b10:   fwd_b = fwd_mem_data;
      default: fwd_b = id_rs2_data;
    endcase
  end

  assign op_b = id_alu_src ? id_imm : fwd_b;

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (id_alu_ctrl)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign alu_zero = (alu_res == '0);
  assign id_ready = !valid_q || mem_ready;
  assign accept   = id_valid && id_ready && !flush;

  // Flush beats accept beats consume; otherwise the entry (and its data) is held.
  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    store_d     = store_q;
    target_d    = target_q;
    zero_d      = zero_q;
    taken_d     = taken_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    rd_d        = rd_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      result_d    = alu_res;
      store_d     = fwd_b;
      target_d    = id_pc + id_imm;
      zero_d      = alu_zero;
      taken_d     = id_branch && alu_zero && !alu_illegal;
      reg_write_d = id_reg_write;
      illegal_d   = alu_illegal;
      rd_d        = id_rd;
    end else if (mem_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      target_q    <= '0;
      zero_q      <= 1'b0;
      taken_q     <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
      rd_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      store_q     <= store_d;
      target_q    <= target_d;
      zero_q      <= zero_d;
      taken_q     <= taken_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
      rd_q        <= rd_d;
    end
  end

  assign ex_valid         = valid_q;
  assign ex_alu_result    = result_q;
  assign ex_store_data    = store_q;
  assign ex_branch_target = target_q;
  assign ex_zero          = zero_q;
  assign ex_illegal       = illegal_q;
  assign ex_rd            = rd_q;
  // Side-effect flags must never leak from an empty stage.
  assign ex_reg_write     = valid_q && reg_write_q;
  assign ex_branch_taken  = valid_q && taken_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vector table, stall/flush/reset sequences and
// randomized traffic against a behavioural model.
module tb_ex_stage;

  logic        clk, rst_n;
  logic        id_valid, id_ready;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_alu_src, id_branch, id_reg_write;
  logic [4:0]  id_rd;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        flush, mem_ready;
  logic        ex_valid;
  logic [31:0] ex_alu_result, ex_store_data, ex_branch_target;
  logic        ex_zero, ex_branch_taken, ex_reg_write, ex_illegal;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_alu_ctrl(id_alu_ctrl),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_reg_write(id_reg_write),
    .id_rd(id_rd), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .mem_ready(mem_ready),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_branch_target(ex_branch_target), .ex_zero(ex_zero),
    .ex_branch_taken(ex_branch_taken), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal), .ex_rd(ex_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1, rs2, imm, pc, mem_d, wb_d;
    logic [3:0]  ctrl;
    logic        src, br, rw;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
    logic [31:0] e_res, e_store, e_tgt;
    logic        e_zero, e_taken, e_ill;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1_data  = v.rs1;  id_rs2_data = v.rs2;  id_imm = v.imm;  id_pc = v.pc;
    fwd_mem_data = v.mem_d; fwd_wb_data = v.wb_d; id_alu_ctrl = v.ctrl;
    id_alu_src   = v.src;  id_branch = v.br;  id_reg_write = v.rw;  id_rd = v.rd;
    fwd_a_sel    = v.fa;   fwd_b_sel = v.fb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU straight from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, output logic ill);
    ill = 1'b0;
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0101: return a ^ b;
      default: begin ill = 1'b1; return 32'd0; end
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] reg_v,
                                       input logic [31:0] mem_v, input logic [31:0] wb_v);
    if (s == 2'b01) return wb_v;
    if (s == 2'b10) return mem_v;
    return reg_v;
  endfunction

  // Model state
  logic        m_valid, m_zero, m_taken, m_rw, m_ill;
  logic [31:0] m_res, m_store, m_tgt;
  logic [4:0]  m_rd;

  task automatic chk_model(input string tag);
    chk({tag, ".valid"},  {31'd0, ex_valid}, {31'd0, m_valid});
    chk({tag, ".result"}, ex_alu_result, m_res);
    chk({tag, ".store"},  ex_store_data, m_store);
    chk({tag, ".target"}, ex_branch_target, m_tgt);
    chk({tag, ".zero"},   {31'd0, ex_zero}, {31'd0, m_zero});
    chk({tag, ".taken"},  {31'd0, ex_branch_taken}, {31'd0, m_valid & m_taken});
    chk({tag, ".rw"},     {31'd0, ex_reg_write}, {31'd0, m_valid & m_rw});
    chk({tag, ".ill"},    {31'd0, ex_illegal}, {31'd0, m_ill});
    chk({tag, ".rd"},     {27'd0, ex_rd}, {27'd0, m_rd});
  endtask

  vec_t add_v;

  initial begin
    //          rs1           rs2           imm          pc            mem_d         wb_d
    //          ctrl  src br rw rd  fa     fb     res          store        tgt     z t i
    vecs[0] = '{32'd5, 32'd3, 32'd7, 32'd0, 32'd0, 32'd0,
                4'b0000, 1, 0, 1, 5'd1, 2'b00, 2'b00, 32'd12, 32'd3, 32'd7, 0, 0, 0};
    vecs[1] = '{32'h10, 32'h10, 32'h20, 32'h100, 32'd0, 32'd0,
                4'b1000, 0, 1, 0, 5'd0, 2'b00, 2'b00, 32'd0, 32'h10, 32'h120, 1, 1, 0};
    vecs[2] = '{32'h1234, 32'h0F, 32'd0, 32'd0, 32'hF0, 32'd0,
                4'b0110, 0, 0, 1, 5'd2, 2'b10, 2'b00, 32'hFF, 32'h0F, 32'd0, 0, 0, 0};
    vecs[3] = '{32'h0000FFFF, 32'h5, 32'd0, 32'h200, 32'd0, 32'hABCD0000,
                4'b0111, 0, 1, 1, 5'd3, 2'b00, 2'b01, 32'd0, 32'hABCD0000, 32'h200, 1, 1, 0};
    vecs[4] = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'h40, 32'd0, 32'd0,
                4'b0000, 0, 0, 1, 5'd4, 2'b00, 2'b00, 32'd0, 32'd1, 32'h40, 1, 0, 0};
    vecs[5] = '{32'd5, 32'd5, 32'd0, 32'h80, 32'd0, 32'd0,
                4'b0011, 0, 1, 1, 5'd5, 2'b00, 2'b00, 32'd0, 32'd5, 32'h80, 1, 0, 1};
    vecs[6] = '{32'hFF00FF00, 32'h0FF00FF0, 32'd0, 32'd0, 32'd0, 32'd0,
                4'b0101, 0, 0, 0, 5'd31, 2'b11, 2'b11, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,
                0, 0, 0};
    vecs[7] = '{32'd3, 32'd9, 32'd5, 32'hFFFFFFF0, 32'd0, 32'd0,
                4'b1000, 1, 1, 1, 5'd7, 2'b00, 2'b00, 32'hFFFFFFFE, 32'd9, 32'hFFFFFFF5,
                0, 0, 0};
    add_v = vecs[0];

    rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    drive(vecs[0]);
    #12;
    chk("rst.valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.result", ex_alu_result, 32'd0);
    chk("rst.target", ex_branch_target, 32'd0);
    chk("rst.rd", {27'd0, ex_rd}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vector table, one instruction per cycle
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      id_valid = 1'b1; mem_ready = 1'b1; flush = 1'b0;
      tick();
      chk($sformatf("vec%0d.valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("vec%0d.result", i), ex_alu_result, vecs[i].e_res);
      chk($sformatf("vec%0d.store", i), ex_store_data, vecs[i].e_store);
      chk($sformatf("vec%0d.target", i), ex_branch_target, vecs[i].e_tgt);
      chk($sformatf("vec%0d.zero", i), {31'd0, ex_zero}, {31'd0, vecs[i].e_zero});
      chk($sformatf("vec%0d.taken", i), {31'd0, ex_branch_taken}, {31'd0, vecs[i].e_taken});
      chk($sformatf("vec%0d.ill", i), {31'd0, ex_illegal}, {31'd0, vecs[i].e_ill});
      chk($sformatf("vec%0d.rw", i), {31'd0, ex_reg_write}, {31'd0, vecs[i].rw});
      chk($sformatf("vec%0d.rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
    end
    id_valid = 1'b0;
    tick();
    chk("drain.valid", {31'd0, ex_valid}, 32'd0);
    chk("drain.rw", {31'd0, ex_reg_write}, 32'd0);

    // Stall for three cycles, then flush while stalled
    drive(add_v); id_valid = 1'b1;
    tick();
    mem_ready = 1'b0; id_rs1_data = 32'd100;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.id_ready", {31'd0, id_ready}, 32'd0);
      tick();
      chk("stall.valid", {31'd0, ex_valid}, 32'd1);
      chk("stall.result", ex_alu_result, 32'd12);
    end
    flush = 1'b1;
    tick();
    chk("flush_stall.valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_stall.rw", {31'd0, ex_reg_write}, 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("flush_incoming.valid", {31'd0, ex_valid}, 32'd0);
    flush = 1'b0;
    tick();
    chk("after_flush.valid", {31'd0, ex_valid}, 32'd1);
    chk("after_flush.result", ex_alu_result, 32'd107);

    // Async reset mid-cycle during a stall
    id_valid = 1'b0; mem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst.valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst.result", ex_alu_result, 32'd0);
    chk("async_rst.rw", {31'd0, ex_reg_write}, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst.idle", {31'd0, ex_valid}, 32'd0);
    drive(add_v); id_valid = 1'b1;
    tick();
    chk("post_rst.valid", {31'd0, ex_valid}, 32'd1);
    chk("post_rst.result", ex_alu_result, 32'd12);

    // Randomized traffic from a clean reset
    id_valid = 1'b0; mem_ready = 1'b1;
    rst_n = 1'b0; #1 rst_n = 1'b1;
    m_valid = 0; m_zero = 0; m_taken = 0; m_rw = 0; m_ill = 0;
    m_res = 0; m_store = 0; m_tgt = 0; m_rd = 0;
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  ops [6];
      logic [31:0] a, bf, b, r;
      logic        ill, rdy, acc;
      ops = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0101, 4'($urandom_range(0, 15))};
      id_alu_ctrl  = ops[$urandom_range(0, 5)];
      id_rs1_data  = $urandom;
      id_rs2_data  = ($urandom_range(0, 3) == 0) ? id_rs1_data : $urandom;
      id_imm       = $urandom;
      id_pc        = $urandom;
      fwd_mem_data = $urandom;
      fwd_wb_data  = $urandom;
      fwd_a_sel    = 2'($urandom_range(0, 3));
      fwd_b_sel    = 2'($urandom_range(0, 3));
      id_alu_src   = ($urandom_range(0, 1) == 1);
      id_branch    = ($urandom_range(0, 1) == 1);
      id_reg_write = ($urandom_range(0, 1) == 1);
      id_rd        = 5'($urandom_range(0, 31));
      id_valid     = ($urandom_range(0, 9) < 7);
      mem_ready    = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 9) == 0);
      #1;
      rdy = !m_valid || mem_ready;
      chk("rand.id_ready", {31'd0, id_ready}, {31'd0, rdy});
      acc = id_valid && rdy && !flush;
      a  = pick(fwd_a_sel, id_rs1_data, fwd_mem_data, fwd_wb_data);
      bf = pick(fwd_b_sel, id_rs2_data, fwd_mem_data, fwd_wb_data);
      b  = id_alu_src ? id_imm : bf;
      r  = ref_alu(id_alu_ctrl, a, b, ill);
      tick();
      if (flush) begin
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1; m_res = r; m_store = bf; m_tgt = id_pc + id_imm;
        m_zero = (r == 0); m_taken = id_branch && (r == 0) && !ill;
        m_rw = id_reg_write; m_ill = ill; m_rd = id_rd;
      end else if (m_valid && mem_ready) begin
        m_valid = 1'b0;
      end
      chk_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
